mem_bus_arbiter: RTL and testbench

//   Shares one single-port data memory (Altera RAM wrapper, 16-bit words) between NUM_REQ requesters,
//   e.g. the SPI->MIL and MIL->SPI ring-buffer engines inside the MIL/SPI converter core.

---
 rtl/mem_bus_arbiter_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_rr_priority_picker.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
// Holds the arbiter state encoding and the default port widths.
package memArbPkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RWAIT,
        RACK
    } ArbState;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_RD_LATENCY = 2;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: returns the first set bit of the
// eligible mask at or after the pointer, wrapping from NUM_REQ-1 to 0.
module rr_priority_picker
    import memArbPkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        w_cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (eligible_i[w_cand]) begin
                grant_o = w_cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ
// requesters with a req/ack handshake and a fixed memory read latency.
module mem_bus_arbiter
    import memArbPkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic                      mem_wren_o,
    output logic                      mem_rden_o,
    input  logic [DATA_W-1:0]         mem_rdata_i
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    ArbState            r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt;
    logic [NUM_REQ-1:0] r_hold_mask;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_eligible;
    logic [IDX_W-1:0]   w_gnt;
    logic               w_gnt_valid;
    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A requester just acked still shows its old req for one cycle; mask it.
    assign w_eligible = req_i & ~r_hold_mask;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .eligible_i (w_eligible),
        .ptr_i      (r_ptr),
        .grant_o    (w_gnt),
        .valid_o    (w_gnt_valid)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_hold_mask <= '0;
            r_cnt       <= '0;
            ack_o       <= '0;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wren_o  <= 1'b0;
            mem_rden_o  <= 1'b0;
        end else begin
            mem_wren_o  <= 1'b0;
            mem_rden_o  <= 1'b0;
            ack_o       <= '0;
            r_hold_mask <= ack_o;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt      <= w_gnt;
                        r_ptr      <= (w_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
                        mem_addr_o <= w_addr_arr[w_gnt];
                        busy_o     <= 1'b1;
                        if (wr_i[w_gnt]) begin
                            // Writes complete in the strobe cycle, so ack rides along.
                            r_state     <= WRITE;
                            mem_wren_o  <= 1'b1;
                            mem_wdata_o <= w_wdata_arr[w_gnt];
                            ack_o       <= NUM_REQ'(1) << w_gnt;
                        end else begin
                            r_state    <= READ;
                            mem_rden_o <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                end
                READ: begin
                    r_cnt   <= CNT_W'(RD_LATENCY - 1);
                    r_state <= RWAIT;
                end
                RWAIT: begin
                    if (r_cnt == '0) begin
                        rdata_o <= mem_rdata_i;
                        ack_o   <= NUM_REQ'(1) << r_gnt;
                        r_state <= RACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RACK: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: requester queues drive the arbiter, a latency-schedule
// model predicts every output per cycle, and a behavioural RAM closes the loop.
module tb_mem_bus_arbiter;

    localparam int NR   = 2;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int RL   = 2;
    localparam int RING = 16;
    localparam int QMAX = 512;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic             clk  = 1'b0;
    logic             nRst = 1'b0;
    logic [NR-1:0]    req_i   = '0;
    logic [NR-1:0]    wr_i    = '0;
    logic [NR*AW-1:0] addr_i  = '0;
    logic [NR*DW-1:0] wdata_i = '0;
    logic [NR-1:0]    ack_o;
    logic [DW-1:0]    rdata_o;
    logic             busy_o;
    logic [AW-1:0]    mem_addr_o;
    logic [DW-1:0]    mem_wdata_o;
    logic             mem_wren_o;
    logic             mem_rden_o;
    logic [DW-1:0]    mem_rdata_i;

    mem_bus_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LATENCY (RL)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .req_i       (req_i),
        .wr_i        (wr_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wren_o  (mem_wren_o),
        .mem_rden_o  (mem_rden_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: RL-cycle read pipe, junk on the bus outside read slots.
    logic [DW-1:0] ram [0:255] = '{default: '0};
    logic [DW-1:0] rd_pipe [0:RL-1];
    always @(posedge clk) begin
        if (mem_wren_o) ram[mem_addr_o[7:0]] <= mem_wdata_o;
        rd_pipe[0] <= mem_rden_o ? ram[mem_addr_o[7:0]] : 16'hBAD0;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata_i = rd_pipe[RL-1];

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic [NR-1:0] e_ack   [RING];
    bit            e_wren  [RING];
    bit            e_rden  [RING];
    bit            e_busy  [RING];
    bit            e_rdack [RING];
    logic [AW-1:0] e_addr  [RING];
    logic [DW-1:0] e_wdata [RING];
    logic [DW-1:0] e_rdata [RING];

    int            m_free_at;
    int            m_ptr;
    int            m_last_ack [NR];
    logic [AW-1:0] m_addr_hold;
    logic [DW-1:0] m_rdata_hold;
    logic [DW-1:0] shadow [256];

    txn_t rq [NR][QMAX];
    int   rq_head [NR];
    int   rq_tail [NR];
    int   gap [NR];
    bit   keep [NR];
    bit   rnd_mode = 1'b0;
    int   raise_cyc [NR];
    int   ack_seen [NR];
    int   ack_order [$];
    int   ack_cyc_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq[k][rq_tail[k]] = '{wr: wr, addr: a, data: d};
        rq_tail[k]++;
    endtask

    task automatic drive_payload(input int k, input txn_t t);
        wr_i[k]               = t.wr;
        addr_i[k*AW +: AW]    = t.addr;
        wdata_i[k*DW +: DW]   = t.data;
    endtask

    task automatic scramble(input int k);
        wr_i[k]             = 1'($urandom);
        addr_i[k*AW +: AW]  = AW'($urandom);
        wdata_i[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic model_reset();
        for (int i = 0; i < RING; i++) begin
            e_ack[i] = '0; e_wren[i] = 0; e_rden[i] = 0; e_busy[i] = 0; e_rdack[i] = 0;
            e_addr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
        end
        for (int k = 0; k < NR; k++) begin
            m_last_ack[k] = -10; rq_head[k] = 0; rq_tail[k] = 0; gap[k] = 0;
            ack_seen[k] = -100; raise_cyc[k] = 0;
        end
        m_free_at = 0; m_ptr = 0; m_addr_hold = '0; m_rdata_hold = '0; req_i = '0;
    endtask

    // One clock: check this cycle's outputs, advance requesters, schedule any grant.
    task automatic step();
        int s, g, n1, na, cand;
        txn_t t;
        @(negedge clk);
        cyc++;
        s = cyc % RING;
        if (e_wren[s] || e_rden[s]) m_addr_hold = e_addr[s];
        if (e_rdack[s]) m_rdata_hold = e_rdata[s];
        chk("ack_o", ack_o, e_ack[s]);
        chk("busy_o", busy_o, e_busy[s]);
        chk("mem_wren_o", mem_wren_o, e_wren[s]);
        chk("mem_rden_o", mem_rden_o, e_rden[s]);
        chk("mem_addr_o", mem_addr_o, m_addr_hold);
        chk("rdata_o", rdata_o, m_rdata_hold);
        chk("strobe_excl", mem_wren_o & mem_rden_o, 0);
        if (e_wren[s]) chk("mem_wdata_o", mem_wdata_o, e_wdata[s]);
        for (int k = 0; k < NR; k++) begin
            if (ack_o[k] === 1'b1) begin
                ack_seen[k] = cyc;
                ack_order.push_back(k);
                ack_cyc_q.push_back(cyc);
                $display("txn: req%0d acked at cyc %0d addr=%h rdata=%h", k, cyc, mem_addr_o, rdata_o);
            end
        end
        for (int k = 0; k < NR; k++) begin
            if (e_ack[s][k]) begin
                m_last_ack[k] = cyc;
                rq_head[k]++;
                if (rnd_mode) keep[k] = 1'($urandom_range(0, 1));
                if (keep[k] && rq_head[k] != rq_tail[k]) begin
                    drive_payload(k, rq[k][rq_head[k]]);
                    raise_cyc[k] = cyc;
                end else begin
                    req_i[k] = 1'b0;
                    gap[k]   = rnd_mode ? int'($urandom_range(0, 3)) : 0;
                    scramble(k);
                end
            end else if (!req_i[k] && rq_head[k] != rq_tail[k]) begin
                if (gap[k] > 0) gap[k]--;
                else begin
                    req_i[k] = 1'b1;
                    drive_payload(k, rq[k][rq_head[k]]);
                    raise_cyc[k] = cyc;
                end
            end else if (!req_i[k]) begin
                scramble(k);
            end
        end
        if (cyc >= m_free_at) begin
            g = -1;
            for (int i = 0; i < NR; i++) begin
                cand = (m_ptr + i) % NR;
                if (g < 0 && req_i[cand] && m_last_ack[cand] != cyc - 1) g = cand;
            end
            if (g >= 0) begin
                t     = rq[g][rq_head[g]];
                m_ptr = (g + 1) % NR;
                n1    = (cyc + 1) % RING;
                e_addr[n1] = t.addr;
                if (t.wr) begin
                    e_wren[n1] = 1; e_wdata[n1] = t.data; e_ack[n1][g] = 1'b1; e_busy[n1] = 1;
                    shadow[t.addr[7:0]] = t.data;
                    m_free_at = cyc + 2;
                end else begin
                    e_rden[n1] = 1;
                    for (int d = 1; d <= 2 + RL; d++) e_busy[(cyc + d) % RING] = 1;
                    na = (cyc + 2 + RL) % RING;
                    e_ack[na][g] = 1'b1; e_rdack[na] = 1; e_rdata[na] = shadow[t.addr[7:0]];
                    m_free_at = cyc + 3 + RL;
                end
            end
        end
        e_ack[s] = '0; e_wren[s] = 0; e_rden[s] = 0; e_busy[s] = 0; e_rdack[s] = 0;
    endtask

    task automatic run_idle(input int budget);
        int  n;
        bit  pend;
        n    = 0;
        pend = 1;
        while (pend && n < budget) begin
            step();
            n++;
            pend = (req_i != '0) || (cyc < m_free_at);
            for (int k = 0; k < NR; k++) if (rq_head[k] != rq_tail[k]) pend = 1;
        end
        chk("drain_within_budget", pend, 0);
        step();
        step();
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        #1;
        chk("rst_ack_o", ack_o, 0);
        chk("rst_busy_o", busy_o, 0);
        chk("rst_mem_wren_o", mem_wren_o, 0);
        chk("rst_mem_rden_o", mem_rden_o, 0);
        chk("rst_mem_addr_o", mem_addr_o, 0);
        chk("rst_mem_wdata_o", mem_wdata_o, 0);
        chk("rst_rdata_o", rdata_o, 0);
        model_reset();
        step();
        step();
        nRst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        for (int k = 0; k < NR; k++) keep[k] = 0;
        model_reset();
        repeat (3) step();
        nRst = 1'b1;
        step();

        // Reset in the middle of a read: no ack may follow
        push(1, 1'b0, 16'h0020, 16'h0000);
        step(); step(); step();
        do_reset();
        repeat (6) step();

        // Single write, then read-back by the other requester
        push(0, 1'b1, 16'h0010, 16'hEFAB);
        run_idle(100);
        chk("t2_write_latency", ack_seen[0] - raise_cyc[0], 1);
        push(1, 1'b0, 16'h0010, 16'h0000);
        run_idle(100);
        chk("t3_read_latency", ack_seen[1] - raise_cyc[1], RL + 2);
        chk("t3_rdata", rdata_o, 16'hEFAB);

        // Contention from reset, then both requesters streaming back to back
        do_reset();
        ack_order.delete();
        push(0, 1'b1, 16'h0030, 16'h1111);
        push(1, 1'b1, 16'h0031, 16'h2222);
        run_idle(100);
        keep[0] = 1; keep[1] = 1;
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b1, AW'(16'h0040 + i), DW'(16'h4000 + i));
            push(1, 1'b1, AW'(16'h0050 + i), DW'(16'h5000 + i));
        end
        run_idle(200);
        chk("t4_ack_count", ack_order.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t4_order%0d", i), (i < ack_order.size()) ? ack_order[i] : -1, i % 2);

        // Same requester back to back: next grant no earlier than ack+2
        keep[1] = 0;
        ack_cyc_q.delete();
        push(0, 1'b1, 16'h0010, 16'h1234);
        push(0, 1'b1, 16'h0011, 16'h9D4D);
        run_idle(100);
        chk("t5_ack_gap", (ack_cyc_q.size() >= 2) ? ack_cyc_q[1] - ack_cyc_q[0] : -1, 3);
        keep[0] = 0;
        push(1, 1'b0, 16'h0011, 16'h0000);
        run_idle(100);
        chk("t5_rdata", rdata_o, 16'h9D4D);

        // Ring pattern: writer wraps 0x7E..0x00 while reader walks 0x80..0x82
        for (int i = 0; i < 3; i++) push(1, 1'b1, AW'(16'h0080 + i), DW'(16'hA080 + i));
        run_idle(100);
        push(0, 1'b1, 16'h007E, 16'hC07E);
        push(0, 1'b1, 16'h007F, 16'hC07F);
        push(0, 1'b1, 16'h0000, 16'hC000);
        for (int i = 0; i < 3; i++) push(1, 1'b0, AW'(16'h0080 + i), 16'h0000);
        run_idle(200);
        chk("t6_last_rdata", rdata_o, 16'hA082);

        // Randomised traffic against the schedule model
        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < NR; k++)
                push(k, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
        end
        run_idle(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
